// File: rtl/complete_cdb_buffer.sv
// In-order completion FIFO between execute and the CDB: one capture and one broadcast per cycle.
// Optional zero-latency empty-buffer bypass when COMPLETE_BYPASS_EN is defined.
module complete_cdb_buffer #(
   parameter int XLEN   = 32,
   parameter int PREG_W = 6,
   parameter int ROB_W  = 5,
   parameter int DEPTH  = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         squash,
   input  logic                         ex_valid,
   output logic                         ex_ready,
   input  logic [PREG_W-1:0]            ex_tag,
   input  logic                         ex_tag_valid,
   input  logic [ROB_W-1:0]             ex_rob_idx,
   input  logic [XLEN-1:0]              ex_result,
   input  logic [XLEN-1:0]              ex_npc,
   input  logic                         ex_take_branch,
   input  logic                         ex_halt,
   output logic                         cdb_valid,
   input  logic                         cdb_ready,
   output logic [PREG_W-1:0]            cdb_tag,
   output logic                         cdb_tag_valid,
   output logic [ROB_W-1:0]             cdb_rob_idx,
   output logic [XLEN-1:0]              cdb_result,
   output logic [XLEN-1:0]              cdb_npc,
   output logic                         cdb_take_branch,
   output logic                         cdb_halt,
   output logic                         almost_full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [PREG_W-1:0] tag;
      logic              tag_valid;
      logic [ROB_W-1:0]  rob_idx;
      logic [XLEN-1:0]   result;
      logic [XLEN-1:0]   npc;
      logic              take_branch;
      logic              halt;
   } entry_t;

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic [DEPTH-1:0] r_vld;
   entry_t           r_mem [DEPTH];

   entry_t w_ex;
   entry_t w_out;
   entry_t w_bcast;
   logic   w_ready;
   logic   w_stored;
   logic   w_cdb_valid;
   logic   w_push;
   logic   w_pop;

   always_comb begin
      w_ex             = '0;
      w_ex.tag         = ex_tag;
      w_ex.tag_valid   = ex_tag_valid;
      w_ex.rob_idx     = ex_rob_idx;
      w_ex.result      = ex_result;
      w_ex.npc         = ex_npc;
      w_ex.take_branch = ex_take_branch;
      w_ex.halt        = ex_halt;
   end

   // Full is judged before any same-cycle pop, so a full buffer never accepts.
   assign w_ready  = (r_count < CNT_W'(DEPTH));
   assign w_stored = r_vld[r_head] & (r_count != '0);

`ifdef COMPLETE_BYPASS_EN
   logic w_bypass;
   assign w_bypass    = (r_count == '0) & ex_valid & !squash;
   assign w_cdb_valid = (w_stored | w_bypass) & !squash;
   assign w_out       = w_bypass ? w_ex : r_mem[r_head];
   // A bypassed result accepted by the CDB is never written; a refused one is stored and held.
   assign w_push      = ex_valid & w_ready & !squash & !(w_bypass & cdb_ready);
   assign w_pop       = w_cdb_valid & cdb_ready & !w_bypass;
`else
   assign w_cdb_valid = w_stored & !squash;
   assign w_out       = r_mem[r_head];
   assign w_push      = ex_valid & w_ready & !squash;
   assign w_pop       = w_cdb_valid & cdb_ready;
`endif

   assign w_bcast = w_cdb_valid ? w_out : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_vld   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (squash) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_vld   <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= w_ex;
            r_vld[r_tail] <= 1'b1;
            r_tail        <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_vld[r_head] <= 1'b0;
            r_head        <= r_head + 1'b1;
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   assign ex_ready        = w_ready;
   assign almost_full     = (r_count >= CNT_W'(DEPTH-1));
   assign count           = r_count;
   assign cdb_valid       = w_cdb_valid;
   assign cdb_tag         = w_bcast.tag;
   assign cdb_tag_valid   = w_bcast.tag_valid;
   assign cdb_rob_idx     = w_bcast.rob_idx;
   assign cdb_result      = w_bcast.result;
   assign cdb_npc         = w_bcast.npc;
   assign cdb_take_branch = w_bcast.take_branch;
   assign cdb_halt        = w_bcast.halt;

endmodule

// File: tb/tb_complete_cdb_buffer.sv
// Directed self-checking bench for complete_cdb_buffer (DEPTH=4); expectations hand-computed.
module tb_complete_cdb_buffer;

   logic        clock = 1'b0;
   logic        reset;
   logic        squash;
   logic        ex_valid;
   logic        ex_ready;
   logic [5:0]  ex_tag;
   logic        ex_tag_valid;
   logic [4:0]  ex_rob_idx;
   logic [31:0] ex_result;
   logic [31:0] ex_npc;
   logic        ex_take_branch;
   logic        ex_halt;
   logic        cdb_valid;
   logic        cdb_ready;
   logic [5:0]  cdb_tag;
   logic        cdb_tag_valid;
   logic [4:0]  cdb_rob_idx;
   logic [31:0] cdb_result;
   logic [31:0] cdb_npc;
   logic        cdb_take_branch;
   logic        cdb_halt;
   logic        almost_full;
   logic [2:0]  count;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   complete_cdb_buffer #(.XLEN(32), .PREG_W(6), .ROB_W(5), .DEPTH(4)) dut (
      .clock(clock), .reset(reset), .squash(squash),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_tag(ex_tag), .ex_tag_valid(ex_tag_valid),
      .ex_rob_idx(ex_rob_idx), .ex_result(ex_result), .ex_npc(ex_npc),
      .ex_take_branch(ex_take_branch), .ex_halt(ex_halt),
      .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
      .cdb_tag_valid(cdb_tag_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_result(cdb_result),
      .cdb_npc(cdb_npc), .cdb_take_branch(cdb_take_branch), .cdb_halt(cdb_halt),
      .almost_full(almost_full), .count(count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic [5:0] tag, input logic [4:0] rob,
                         input logic [31:0] res);
      ex_valid       = v;
      ex_tag         = tag;
      ex_tag_valid   = 1'b1;
      ex_rob_idx     = rob;
      ex_result      = res;
      ex_npc         = res + 32'd4;
      ex_take_branch = tag[0];
      ex_halt        = 1'b0;
   endtask

   task automatic push_n(input int n, input logic [5:0] tag0);
      for (int i = 0; i < n; i++) begin
         set_ex(1'b1, tag0 + 6'(i), 5'(i), 32'h100 + 32'(i));
         tick();
      end
      ex_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; squash = 1'b0; cdb_ready = 1'b0;
      set_ex(1'b0, 6'd0, 5'd0, 32'd0);
      tick(); tick();
      chk("rst_cdb_valid", cdb_valid, 1'b0);
      chk("rst_count", count, 3'd0);
      chk("rst_ex_ready", ex_ready, 1'b1);
      chk("rst_almost_full", almost_full, 1'b0);
      chk("rst_cdb_result", cdb_result, 32'd0);
      reset = 1'b1;
      tick();

      // 1: async reset with three entries held
      push_n(3, 6'd10);
      chk("t1_count3", count, 3'd3);
      chk("t1_head_tag", cdb_tag, 6'd10);
      #2 reset = 1'b0;
      #1;
      chk("t1_cdb_valid", cdb_valid, 1'b0);
      chk("t1_count", count, 3'd0);
      chk("t1_ex_ready", ex_ready, 1'b1);
      chk("t1_almost_full", almost_full, 1'b0);
      #2 reset = 1'b1;
      tick();

      // 2: single push to empty buffer
      cdb_ready = 1'b1;
      set_ex(1'b1, 6'd5, 5'd3, 32'h1234);
`ifdef COMPLETE_BYPASS_EN
      #1;
      chk("t2_byp_valid", cdb_valid, 1'b1);
      chk("t2_byp_tag", cdb_tag, 6'd5);
      chk("t2_byp_rob", cdb_rob_idx, 5'd3);
      chk("t2_byp_result", cdb_result, 32'h1234);
      tick();
      ex_valid = 1'b0;
      #1;
      chk("t2_byp_count", count, 3'd0);
`else
      #1;
      chk("t2_pre_valid", cdb_valid, 1'b0);
      tick();
      ex_valid = 1'b0;
      #1;
      chk("t2_valid", cdb_valid, 1'b1);
      chk("t2_tag", cdb_tag, 6'd5);
      chk("t2_rob", cdb_rob_idx, 5'd3);
      chk("t2_result", cdb_result, 32'h1234);
      chk("t2_npc", cdb_npc, 32'h1238);
      tick();
      chk("t2_count", count, 3'd0);
      chk("t2_drained", cdb_valid, 1'b0);
`endif

      // 3: fill to full, overflow attempt, then drain in order
      cdb_ready = 1'b0;
      push_n(3, 6'd20);
      chk("t3_af_at3", almost_full, 1'b1);
      chk("t3_ready_at3", ex_ready, 1'b1);
      set_ex(1'b1, 6'd23, 5'd3, 32'h103);
      tick();
      chk("t3_count4", count, 3'd4);
      chk("t3_ex_ready", ex_ready, 1'b0);
      chk("t3_almost_full", almost_full, 1'b1);
      set_ex(1'b1, 6'd31, 5'd9, 32'hDEAD);
      tick();
      ex_valid = 1'b0;
      chk("t3_overflow_count", count, 3'd4);
      chk("t3_held_tag", cdb_tag, 6'd20);
      chk("t3_held_valid", cdb_valid, 1'b1);
      cdb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t3_order_valid", cdb_valid, 1'b1);
         chk("t3_order_tag", cdb_tag, 6'd20 + 6'(i));
         chk("t3_order_result", cdb_result, 32'h100 + 32'(i));
         tick();
      end
      chk("t3_empty", count, 3'd0);

      // 4: steady push+pop with pointer wrap
      cdb_ready = 1'b0;
      push_n(2, 6'd40);
      cdb_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_ex(1'b1, 6'd42 + 6'(i), 5'(i), 32'h200 + 32'(i));
         #1;
         chk("t4_tag", cdb_tag, 6'd40 + 6'(i));
         tick();
         chk("t4_count", count, 3'd2);
      end
      ex_valid = 1'b0;
      #1;
      chk("t4_tail_tag0", cdb_tag, 6'd50);
      tick();
      chk("t4_tail_tag1", cdb_tag, 6'd51);
      tick();
      chk("t4_drained", count, 3'd0);

      // 5: squash with a push pending
      cdb_ready = 1'b0;
      push_n(3, 6'd1);
      set_ex(1'b1, 6'd60, 5'd7, 32'hBAD);
      squash = 1'b1;
      #1;
      chk("t5_sq_valid", cdb_valid, 1'b0);
      tick();
      squash = 1'b0;
      ex_valid = 1'b0;
      #1;
      chk("t5_count", count, 3'd0);
      chk("t5_valid", cdb_valid, 1'b0);
      set_ex(1'b1, 6'd7, 5'd2, 32'h77);
      tick();
      ex_valid = 1'b0;
      #1;
      chk("t5_next_tag", cdb_tag, 6'd7);
      chk("t5_next_count", count, 3'd1);
      cdb_ready = 1'b1;
      tick();
      chk("t5_drained", count, 3'd0);

      // 6: full buffer pops but refuses a same-cycle push
      cdb_ready = 1'b0;
      push_n(4, 6'd8);
      chk("t6_full", count, 3'd4);
      cdb_ready = 1'b1;
      set_ex(1'b1, 6'd62, 5'd1, 32'h62);
      tick();
      ex_valid = 1'b0;
      #1;
      chk("t6_count3", count, 3'd3);
      for (int i = 0; i < 3; i++) begin
         chk("t6_tag", cdb_tag, 6'd9 + 6'(i));
         tick();
      end
      chk("t6_drained", count, 3'd0);
      chk("t6_no_refused", cdb_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
